rca_serial_adder: RTL and testbench

Multi-cycle wide adder that computes a WIDTH-bit sum one nibble per clock. It reuses a single instance of the team's 4-bit ripple-carry adder `RCA` (ports a, b, cin, sum, cout) as its datapath. The block drives the RCA operands and carry-in, and consumes the RCA sum and carry-out. It sits between a requesting controller (start/done handshake) and any consumer of wide sums.

---
 rtl/rca_serial_adder.sv | 184 ++++++++++++++++++
 tb/tb_rca_serial_adder.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/rca_serial_adder.sv
// Purpose : WIDTH-bit adder that runs one nibble per clock through a single 4-bit RCA.
// Latency : start accepted at E0, done pulses in the cycle after E(NIB); next start at E(NIB+2).
// Backpr. : none; start is ignored while busy or in DONE, so callers must wait for done.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   start             request, sampled only in IDLE
//   a_in, b_in, cin   operands and carry-in, captured on an accepted start
//   busy              high while nibbles are being added
//   done              one-cycle pulse, result valid
//   sum, cout         registered WIDTH-bit result and final carry-out
//   overflow          registered two's-complement overflow of the result
module rca_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int NIB   = WIDTH / 4;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               carry_q, carry_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [3:0]         rca_a, rca_b, rca_sum;
    logic               rca_cout;
    logic               last_nib;

    // Shared nibble datapath; operands are muxed by the current nibble index.
    RCA u_rca (
        .a    (rca_a),
        .b    (rca_b),
        .cin  (carry_q),
        .sum  (rca_sum),
        .cout (rca_cout)
    );

    assign rca_a    = a_q[4*idx_q +: 4];
    assign rca_b    = b_q[4*idx_q +: 4];
    assign last_nib = (idx_q == IDX_W'(NIB - 1));

    // State register and datapath flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_ADD;
            S_ADD:   if (last_nib) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and output-flag updates per state.
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a_in;
                    b_d     = b_in;
                    carry_d = cin;
                    idx_d   = '0;
                    sum_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            S_ADD: begin
                sum_d[4*idx_q +: 4] = rca_sum;
                carry_d             = rca_cout;
                idx_d               = idx_q + IDX_W'(1);
                if (last_nib) begin
                    idx_d  = '0;
                    cout_d = rca_cout;
                    // rca_sum[3] is the new MSB of the full result.
                    ovf_d  = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                             (rca_sum[3] != a_q[WIDTH-1]);
                    busy_d = 1'b0;
                    done_d = 1'b1;
                end
            end
            S_DONE: begin
                done_d = 1'b0;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign sum      = sum_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;

endmodule

// Purpose : 4-bit ripple-carry adder, the shared nibble datapath.
// Latency : combinational.
// Backpr. : none.
//
// Ports: a, b (4-bit operands), cin (carry-in), sum (4-bit), cout (carry-out).
module RCA (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < 4; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout = c[4];

endmodule

// File: tb/tb_rca_serial_adder.sv
module tb_rca_serial_adder;

    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a_in, b_in;
    logic             cin;
    logic             busy, done, cout, overflow;
    logic [WIDTH-1:0] sum;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    rca_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a_in     (a_in),
        .b_in     (b_in),
        .cin      (cin),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .cout     (cout),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    // Reference: unsigned and signed integer arithmetic on the whole operands.
    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic c);
        exp_t   m;
        longint us, ss, lim;
        us     = longint'(a) + longint'(b) + longint'(c);
        ss     = longint'($signed(a)) + longint'($signed(b)) + longint'(c);
        lim    = longint'(1) <<< (WIDTH - 1);
        m.sum  = us[WIDTH-1:0];
        m.cout = (us >= (longint'(1) <<< WIDTH));
        m.ovf  = (ss > lim - 1) || (ss < -lim);
        return m;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every done pulse consumes one expected result.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            chk("busy_done_excl", {31'd0, (busy === 1'b1) && (done === 1'b1)}, 32'd0);
            if (done === 1'b1) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 expected no pulse at %0t", $time);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("sum",      {16'd0, sum},      {16'd0, e.sum});
                    chk("cout",     {31'd0, cout},     {31'd0, e.cout});
                    chk("overflow", {31'd0, overflow}, {31'd0, e.ovf});
                end
            end
        end
    end

    // Present a request for one edge, then scramble the inputs.
    task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic c, input bit push);
        @(negedge clk);
        start = 1'b1;
        a_in  = a;
        b_in  = b;
        cin   = c;
        @(posedge clk);
        #1;
        start = 1'b0;
        a_in  = WIDTH'($urandom);
        b_in  = WIDTH'($urandom);
        cin   = 1'($urandom);
        if (push) sb_q.push_back(model(a, b, c));
    endtask

    // Returns at the negedge of the DONE cycle.
    task automatic wait_done();
        int  busy_cnt;
        bit  seen;
        busy_cnt = 0;
        seen     = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen = 1'b1;
                chk("done_latency", k, NIB);
                chk("busy_cycles", busy_cnt, NIB);
                break;
            end
            if (busy === 1'b1) busy_cnt++;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done expected done within 20 cycles");
        end
    endtask

    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic c);
        start_op(a, b, c, 1'b1);
        wait_done();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200us");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        cin   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_sum",  {16'd0, sum},  32'd0);
        chk("rst_cout", {31'd0, cout}, 32'd0);
        chk("rst_ovf",  {31'd0, overflow}, 32'd0);
        rst = 1'b0;

        // Zero operands, then a carry that ripples across nibbles.
        run_op(16'h0000, 16'h0000, 1'b0);
        run_op(16'h1234, 16'h0FCD, 1'b1);

        // Idle with start low: result must hold.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_sum",  {16'd0, sum},  32'h2202);
            chk("hold_done", {31'd0, done}, 32'd0);
            chk("hold_busy", {31'd0, busy}, 32'd0);
        end

        // Wrap with carry-out, then signed overflow.
        run_op(16'hFFFF, 16'h0001, 1'b0);
        run_op(16'h7FFF, 16'h0001, 1'b0);

        // start toggling and operand churn while busy and in DONE.
        start_op(16'h1111, 16'h2222, 1'b0, 1'b1);
        for (int i = 0; i < NIB + 1; i++) begin
            @(negedge clk);
            chk("t4_done_timing", {31'd0, done}, (i == NIB) ? 32'd1 : 32'd0);
            start = (i % 2 == 0);
            a_in  = WIDTH'($urandom);
            b_in  = WIDTH'($urandom);
        end
        run_op(16'hABCD, 16'h1357, 1'b0);

        // Reset mid-operation after two nibbles: abandoned, no done.
        start_op(16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_sum",  {16'd0, sum},  32'd0);
        chk("abort_cout", {31'd0, cout}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("abort_no_done", {31'd0, done}, 32'd0);
        end
        run_op(16'hFFFF, 16'hFFFF, 1'b1);

        // Randomised operations with occasional idle gaps.
        for (int n = 0; n < 40; n++) begin
            run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        chk("sb_empty", sb_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
